align_job_scheduler: RTL and testbench

//  Shares one med_solver instance between NUM_REQ alignment requesters.
//  - Arbitrates among requesters round-robin and latches the winner's lengths and sequences.
//  - Pulses the solver reset to start a job, then waits for solver finished.
//  - Returns the max-score cell (row, col) with the requester id over a valid/ready result port.

---
 rtl/align_job_scheduler_pkg.sv | 14 +
 rtl/align_job_scheduler_rr_arbiter.sv | 30 +++
 rtl/align_job_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_align_job_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/align_job_scheduler_pkg.sv
// Shared types for the alignment job scheduler: nucleotide encoding and FSM state.
package align_job_scheduler_pkg;

  typedef logic [1:0] dna_base;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_CLEAR,
    S_RUN,
    S_RESULT
  } sched_state;

endpackage

// File: rtl/align_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above i_ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_onehot,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);

  localparam int IW = $clog2(N);

  // NOTE: every output gets a default before the search loop so no latch is inferred.
  always_comb begin
    logic [IW-1:0] w_k;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_k = IW'((int'(i_ptr) + i) % N);
      if (!o_any && i_req[w_k]) begin
        o_any         = 1'b1;
        o_idx         = w_k;
        o_onehot[w_k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/align_job_scheduler.sv
// Shares one med_solver between NUM_REQ requesters: round-robin grant, solver start, result return.
// Optional watchdog on the RUN state is built when ALIGN_SCHED_TIMEOUT_EN is defined.
module align_job_scheduler
  import align_job_scheduler_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int MAX_LEN1   = 5,
  parameter  int MAX_LEN2   = 5,
  parameter  int RST_CYCLES = 2,
  parameter  int TIMEOUT    = 4096,
  localparam int IDW        = $clog2(NUM_REQ),
  localparam int L1W        = $clog2(MAX_LEN1) + 2,
  localparam int L2W        = $clog2(MAX_LEN2) + 2,
  localparam int R1W        = $clog2(MAX_LEN1) + 1,
  localparam int R2W        = $clog2(MAX_LEN2) + 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_REQ-1:0]                    i_req_valid,
  output logic [NUM_REQ-1:0]                    o_req_ready,
  input  logic [NUM_REQ-1:0][L1W-1:0]           i_req_len1,
  input  logic [NUM_REQ-1:0][L2W-1:0]           i_req_len2,
  input  dna_base [NUM_REQ-1:0][MAX_LEN1-1:0]   i_req_seq1,
  input  dna_base [NUM_REQ-1:0][MAX_LEN2-1:0]   i_req_seq2,
  output logic                                  o_solver_rst,
  output logic [L1W-1:0]                        o_solver_len1,
  output logic [L2W-1:0]                        o_solver_len2,
  output dna_base [MAX_LEN1-1:0]                o_solver_seq1,
  output dna_base [MAX_LEN2-1:0]                o_solver_seq2,
  input  logic                                  i_solver_finished,
  input  logic [R1W-1:0]                        i_solver_max_row,
  input  logic [R2W-1:0]                        i_solver_max_col,
  output logic                                  o_res_valid,
  input  logic                                  i_res_ready,
  output logic [IDW-1:0]                        o_res_id,
  output logic [R1W-1:0]                        o_res_max_row,
  output logic [R2W-1:0]                        o_res_max_col,
  output logic                                  o_res_err,
  output logic                                  o_busy
);

  localparam int CW = $clog2(RST_CYCLES) + 1;

  sched_state                r_state, w_next;
  logic [IDW-1:0]            r_gnt, r_ptr;
  logic [NUM_REQ-1:0]        r_gnt_oh;
  logic [CW-1:0]             r_clr_cnt;
  logic                      r_run_first;
  logic [L1W-1:0]            r_len1;
  logic [L2W-1:0]            r_len2;
  dna_base [MAX_LEN1-1:0]    r_seq1;
  dna_base [MAX_LEN2-1:0]    r_seq2;
  logic [IDW-1:0]            r_res_id;
  logic [R1W-1:0]            r_res_row;
  logic [R2W-1:0]            r_res_col;
  logic                      r_res_err;

  logic [NUM_REQ-1:0]        w_arb_onehot;
  logic [IDW-1:0]            w_arb_idx;
  logic                      w_arb_any;
  logic signed [L1W-1:0]     w_len1;
  logic signed [L2W-1:0]     w_len2;
  logic                      w_len_bad, w_accept, w_clr_done, w_done, w_timeout;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req    (i_req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_arb_onehot),
    .o_idx    (w_arb_idx),
    .o_any    (w_arb_any)
  );

  assign w_len1     = $signed(i_req_len1[r_gnt]);
  assign w_len2     = $signed(i_req_len2[r_gnt]);
  assign w_len_bad  = (int'(w_len1) < 2) || (int'(w_len1) > MAX_LEN1) ||
                      (int'(w_len2) < 1) || (int'(w_len2) > MAX_LEN2);
  assign w_accept   = (r_state == S_GRANT) && i_req_valid[r_gnt];
  assign w_clr_done = (r_clr_cnt == CW'(RST_CYCLES - 1));
  // The solver's clear can lag one cycle, so a finished flag in the first RUN cycle is stale.
  assign w_done     = (r_state == S_RUN) && !r_run_first && i_solver_finished;

`ifdef ALIGN_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst)                    r_to_cnt <= '0;
    else if (r_state == S_CLEAR)   r_to_cnt <= '0;
    else if (r_state == S_RUN)     r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_RUN) && (r_to_cnt == TW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_arb_any) w_next = S_GRANT;
      S_GRANT:  if (!i_req_valid[r_gnt]) w_next = S_IDLE;
                else if (w_len_bad)      w_next = S_RESULT;
                else                     w_next = S_CLEAR;
      S_CLEAR:  if (w_clr_done) w_next = S_RUN;
      S_RUN:    if (w_done || w_timeout) w_next = S_RESULT;
      S_RESULT: if (i_res_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready  = '0;
    o_solver_rst = 1'b1;
    o_res_valid  = 1'b0;
    o_busy       = 1'b1;
    case (r_state)
      S_IDLE:   o_busy       = 1'b0;
      S_GRANT:  o_req_ready  = r_gnt_oh;
      S_RUN:    o_solver_rst = 1'b0;
      S_RESULT: o_res_valid  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_gnt       <= '0;
      r_gnt_oh    <= '0;
      r_ptr       <= '0;
      r_clr_cnt   <= '0;
      r_run_first <= 1'b0;
      r_len1      <= '0;
      r_len2      <= '0;
      r_seq1      <= '0;
      r_seq2      <= '0;
      r_res_id    <= '0;
      r_res_row   <= '0;
      r_res_col   <= '0;
      r_res_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_arb_any) begin
        r_gnt    <= w_arb_idx;
        r_gnt_oh <= w_arb_onehot;
      end
      if (w_accept) begin
        r_len1   <= i_req_len1[r_gnt];
        r_len2   <= i_req_len2[r_gnt];
        r_seq1   <= i_req_seq1[r_gnt];
        r_seq2   <= i_req_seq2[r_gnt];
        r_res_id <= r_gnt;
        r_ptr    <= (r_gnt == IDW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
        if (w_len_bad) begin
          r_res_err <= 1'b1;
          r_res_row <= '0;
          r_res_col <= '0;
        end
      end
      if (r_state == S_GRANT)      r_clr_cnt <= '0;
      else if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      r_run_first <= (r_state == S_CLEAR);
      if (w_done) begin
        r_res_row <= i_solver_max_row;
        r_res_col <= i_solver_max_col;
        r_res_err <= 1'b0;
      end else if (w_timeout) begin
        r_res_row <= '0;
        r_res_col <= '0;
        r_res_err <= 1'b1;
      end
    end
  end

  assign o_solver_len1 = r_len1;
  assign o_solver_len2 = r_len2;
  assign o_solver_seq1 = r_seq1;
  assign o_solver_seq2 = r_seq2;
  assign o_res_id      = r_res_id;
  assign o_res_max_row = r_res_row;
  assign o_res_max_col = r_res_col;
  assign o_res_err     = r_res_err;

endmodule

// File: tb/tb_align_job_scheduler.sv
// Directed bench for align_job_scheduler with a behavioural solver stand-in and a result scoreboard.
module tb_align_job_scheduler;
  import align_job_scheduler_pkg::*;

  localparam int NUM_REQ = 4, MAX_LEN1 = 5, MAX_LEN2 = 5, RST_CYCLES = 2, TIMEOUT = 16;
  localparam int L1W = 5, L2W = 5, R1W = 4, R2W = 4, IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                rst_n;
  logic [NUM_REQ-1:0]                  req_valid, req_ready;
  logic [NUM_REQ-1:0][L1W-1:0]         req_len1;
  logic [NUM_REQ-1:0][L2W-1:0]         req_len2;
  dna_base [NUM_REQ-1:0][MAX_LEN1-1:0] req_seq1;
  dna_base [NUM_REQ-1:0][MAX_LEN2-1:0] req_seq2;
  logic                                solver_rst;
  logic [L1W-1:0]                      solver_len1;
  logic [L2W-1:0]                      solver_len2;
  dna_base [MAX_LEN1-1:0]              solver_seq1;
  dna_base [MAX_LEN2-1:0]              solver_seq2;
  logic                                solver_finished;
  logic [R1W-1:0]                      solver_max_row;
  logic [R2W-1:0]                      solver_max_col;
  logic                                res_valid, res_ready, res_err, busy;
  logic [IDW-1:0]                      res_id;
  logic [R1W-1:0]                      res_max_row;
  logic [R2W-1:0]                      res_max_col;

  align_job_scheduler #(
    .NUM_REQ(NUM_REQ), .MAX_LEN1(MAX_LEN1), .MAX_LEN2(MAX_LEN2),
    .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_len1(req_len1), .i_req_len2(req_len2),
    .i_req_seq1(req_seq1), .i_req_seq2(req_seq2),
    .o_solver_rst(solver_rst), .o_solver_len1(solver_len1), .o_solver_len2(solver_len2),
    .o_solver_seq1(solver_seq1), .o_solver_seq2(solver_seq2),
    .i_solver_finished(solver_finished),
    .i_solver_max_row(solver_max_row), .i_solver_max_col(solver_max_col),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_id(res_id),
    .o_res_max_row(res_max_row), .o_res_max_col(res_max_col),
    .o_res_err(res_err), .o_busy(busy)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [R1W-1:0] row;
    logic [R2W-1:0] col;
    logic           err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Solver stand-in controls
  int   mk_delay = 3;
  logic mk_stale = 1'b0;
  logic mk_stall = 1'b0;
  int   mk_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] enc(input string s);
    logic [9:0] v;
    v = '0;
    for (int k = 0; k < s.len() && k < 5; k++) begin
      case (s[k])
        "C":     v[2*k +: 2] = 2'd1;
        "G":     v[2*k +: 2] = 2'd2;
        "T":     v[2*k +: 2] = 2'd3;
        default: v[2*k +: 2] = 2'd0;
      endcase
    end
    return v;
  endfunction

  // Arbitrary but deterministic "max cell" the fake solver reports for a job
  task automatic model_rc(input int l1, input int l2, input logic [9:0] s1, input logic [9:0] s2,
                          output logic [3:0] row, output logic [3:0] col);
    row = 4'((l1 + int'(s1[3:2])) % 6);
    col = 4'((l2 + int'(s2[1:0]) + int'(s2[9:8]) + int'(s1[9:8])) % 6);
  endtask

  initial begin
    logic [3:0] r, c;
    solver_finished = 1'b0;
    solver_max_row  = '0;
    solver_max_col  = '0;
    forever begin
      @(negedge clk);
      if (solver_rst !== 1'b0) begin
        mk_cnt = 0;
        solver_finished = 1'b0;
        solver_max_row = '0;
        solver_max_col = '0;
      end else begin
        mk_cnt++;
        if (mk_stall) begin
          solver_finished = 1'b0;
        end else if (mk_stale && mk_cnt == 1) begin
          solver_finished = 1'b1;
          solver_max_row = 4'hF;
          solver_max_col = 4'hF;
        end else if (mk_cnt >= mk_delay) begin
          model_rc(int'(solver_len1), int'(solver_len2), solver_seq1, solver_seq2, r, c);
          solver_finished = 1'b1;
          solver_max_row = r;
          solver_max_col = c;
        end else begin
          solver_finished = 1'b0;
        end
      end
    end
  end

  task automatic set_req(input int i, input int l1, input int l2, input string s1, input string s2);
    req_len1[i] = 5'(l1);
    req_len2[i] = 5'(l2);
    req_seq1[i] = enc(s1);
    req_seq2[i] = enc(s2);
  endtask

  task automatic push_exp(input int i, input logic err);
    exp_t e;
    e.id  = IDW'(i);
    e.err = err;
    e.row = '0;
    e.col = '0;
    if (!err) model_rc(int'(req_len1[i]), int'(req_len2[i]), req_seq1[i], req_seq2[i], e.row, e.col);
    sb_q.push_back(e);
  endtask

  task automatic wait_grant(input string tag, input logic [NUM_REQ-1:0] exp_oh);
    int n = 0;
    while (req_ready === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_grant"}, req_ready, exp_oh);
  endtask

  task automatic wait_result(input string tag);
    int   n = 0;
    exp_t e;
    while (res_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_sb"}, sb_q.size() != 0, 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_id"},  res_id,      e.id);
      check({tag, "_row"}, res_max_row, e.row);
      check({tag, "_col"}, res_max_col, e.col);
      check({tag, "_err"}, res_err,     e.err);
    end
  endtask

  task automatic run_job(input string tag, input int i, input int l1, input int l2,
                         input string s1, input string s2, input logic err);
    logic low = 1'b0;
    int   n = 0;
    set_req(i, l1, l2, s1, s2);
    push_exp(i, err);
    req_valid = NUM_REQ'(1) << i;
    wait_grant(tag, NUM_REQ'(1) << i);
    @(negedge clk);
    req_valid = '0;
    while (res_valid !== 1'b1 && n < 200) begin
      if (solver_rst !== 1'b1) low = 1'b1;
      @(negedge clk);
      n++;
    end
    if (err) check({tag, "_srst_held"}, low, 0);
    wait_result(tag);
    check({tag, "_srst_result"}, solver_rst, 1);
    @(negedge clk);
  endtask

  initial begin
    int         n;
    logic       stable, rdy_seen;
    logic [10:0] snap;

    rst_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    req_len1 = '0;
    req_len2 = '0;
    req_seq1 = '0;
    req_seq2 = '0;
    repeat (2) @(negedge clk);

    check("rst_ready",     req_ready,   0);
    check("rst_res_valid", res_valid,   0);
    check("rst_res_err",   res_err,     0);
    check("rst_res_id",    res_id,      0);
    check("rst_res_row",   res_max_row, 0);
    check("rst_res_col",   res_max_col, 0);
    check("rst_solver_rst", solver_rst, 1);
    check("rst_len1",      solver_len1, 0);
    check("rst_len2",      solver_len2, 0);
    check("rst_seq1",      solver_seq1, 0);
    check("rst_busy",      busy,        0);

    // Single job on requester 0
    rst_n = 1'b1;
    res_ready = 1'b1;
    set_req(0, 5, 5, "CAGTA", "GCATA");
    push_exp(0, 1'b0);
    req_valid = 4'b0001;
    wait_grant("t1", 4'b0001);
    check("t1_busy", busy, 1);
    @(negedge clk);
    req_valid = '0;
    check("t1_ready_1cyc", req_ready, 0);
    check("t1_clear0", solver_rst, 1);
    check("t1_len1", solver_len1, 5);
    check("t1_len2", solver_len2, 5);
    check("t1_seq1", solver_seq1, enc("CAGTA"));
    check("t1_seq2", solver_seq2, enc("GCATA"));
    @(negedge clk);
    check("t1_clear1", solver_rst, 1);
    @(negedge clk);
    check("t1_run", solver_rst, 0);
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t1_run_latency", n, 3);
    wait_result("t1");
    @(negedge clk);
    check("t1_idle_after", busy, 0);

    // Round robin over 8 jobs, with a stale finished flag in each first RUN cycle
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mk_stale = 1'b1;
    set_req(0, 5, 5, "ACGTA", "TTGCA");
    set_req(1, 4, 3, "GGGAC", "CAT");
    set_req(2, 2, 1, "AC",    "G");
    set_req(3, 5, 5, "TTTTT", "AAAAA");
    for (int j = 0; j < 8; j++) push_exp(j % 4, 1'b0);
    req_valid = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      wait_grant($sformatf("rr%0d", j), NUM_REQ'(1) << (j % 4));
      wait_result($sformatf("rr%0d", j));
      if (j == 7) req_valid = '0;
    end
    mk_stale = 1'b0;
    @(negedge clk);

    // Rejected lengths never start the solver
    run_job("err_len1_1",   2,  1, 4, "CA",    "GATC",  1'b1);
    run_job("err_len2_0",   0,  3, 0, "CAG",   "",      1'b1);
    run_job("err_len1_big", 1,  6, 3, "CAGTA", "GAT",   1'b1);
    run_job("err_len1_neg", 3, -2, 2, "CA",    "GA",    1'b1);
    run_job("err_len2_big", 0,  3, 6, "CAG",   "GATCA", 1'b1);
    run_job("ok_after_err", 1,  3, 2, "TGA",   "CC",    1'b0);

    // Result held under back-pressure; a pending request waits for IDLE
    res_ready = 1'b0;
    set_req(1, 4, 4, "GATC", "CCGA");
    push_exp(1, 1'b0);
    req_valid = 4'b0010;
    wait_grant("hold", 4'b0010);
    @(negedge clk);
    req_valid = '0;
    wait_result("hold");
    snap = {res_id, res_max_row, res_max_col, res_err};
    set_req(3, 3, 3, "TAC", "GGT");
    push_exp(3, 1'b0);
    req_valid = 4'b1000;
    stable = 1'b1;
    rdy_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || {res_id, res_max_row, res_max_col, res_err} !== snap) stable = 1'b0;
      if (req_ready !== '0) rdy_seen = 1'b1;
    end
    check("hold_stable", stable, 1);
    check("hold_no_ready", rdy_seen, 0);
    res_ready = 1'b1;
    @(negedge clk);
    check("hold_released", res_valid, 0);
    check("hold_idle_ready", req_ready, 0);
    check("hold_idle_busy", busy, 0);
    @(negedge clk);
    check("hold_next_grant", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    wait_result("hold2");
    @(negedge clk);

    // Reset during RUN aborts the job without a result
    mk_delay = 20;
    set_req(0, 5, 4, "GATTA", "CAGT");
    req_valid = 4'b0001;
    wait_grant("mrst", 4'b0001);
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (solver_rst !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mrst_in_run", solver_rst, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy", busy, 0);
    check("mrst_solver_rst", solver_rst, 1);
    check("mrst_res_valid", res_valid, 0);
    check("mrst_ready", req_ready, 0);
    check("mrst_len1", solver_len1, 0);
    mk_delay = 3;
    @(negedge clk);
    run_job("mrst_next", 1, 4, 5, "CCATG", "GTACA", 1'b0);

`ifdef ALIGN_SCHED_TIMEOUT_EN
    // Watchdog: solver never finishes
    mk_stall = 1'b1;
    set_req(2, 4, 4, "ACGT", "TGCA");
    push_exp(2, 1'b1);
    req_valid = 4'b0100;
    wait_grant("tmo", 4'b0100);
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (solver_rst !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_in_run", solver_rst, 0);
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, TIMEOUT);
    wait_result("tmo");
    mk_stall = 1'b0;
    @(negedge clk);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
